// File: rtl/mips_pkg.sv
// Shared arbitration constants and elaboration helpers for the arb_mux_reg slice.
package mips_pkg;

   // Arbitration policy selectors for the ARB_MODE parameter.
   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Ceiling log2, used to check that SEL_W matches NUM_CH at elaboration.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed lowest-index priority.
module rr_arbiter
   import mips_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int SEL_W    = 2,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              any_grant
);

   // Catch illegal configurations at elaboration rather than in silicon.
   if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("rr_arbiter: NUM_CH must lie in 2..16");
   end
   if (SEL_W != clog2(NUM_CH)) begin : g_bad_sel_w
      $error("rr_arbiter: SEL_W must equal clog2(NUM_CH)");
   end

   logic             hi_hit;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;

   // Find the lowest requester overall and the lowest one at or above ptr;
   // the latter wins in round-robin mode, the former covers the wrap case.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      hi_hit    = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      any_grant = 1'b0;
      grant_idx = '0;
      grant     = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (req[c]) begin
            any_grant = 1'b1;
            lo_idx    = SEL_W'(c);
            if (SEL_W'(c) >= ptr) begin
               hi_hit = 1'b1;
               hi_idx = SEL_W'(c);
            end
         end
      end
      if (ARB_MODE == ARB_RR && hi_hit) begin
         grant_idx = hi_idx;
      end else begin
         grant_idx = lo_idx;
      end
      if (any_grant) begin
         grant = NUM_CH'(1) << grant_idx;
      end
   end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel valid/ready arbiter-mux with a single registered output stage.
module arb_mux_reg
   import mips_pkg::*;
#(
   parameter int DATA_LENGTH = 8,
   parameter int NUM_CH      = 4,
   parameter int SEL_W       = 2,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             in_valid,
   input  logic [NUM_CH*DATA_LENGTH-1:0] in_data,
   output logic [NUM_CH-1:0]             in_ready,
   output logic                          out_valid,
   output logic [DATA_LENGTH-1:0]        out_data,
   output logic [SEL_W-1:0]              out_sel,
   input  logic                          out_ready
);

   logic                   out_valid_q, out_valid_d;
   logic [DATA_LENGTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0]       out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]       rr_ptr_q,    rr_ptr_d;

   logic [NUM_CH-1:0]      grant;
   logic [SEL_W-1:0]       grant_idx;
   logic                   any_grant;
   logic                   load_en;
   logic [DATA_LENGTH-1:0] sel_data;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .SEL_W    (SEL_W),
      .ARB_MODE (ARB_MODE)
   ) u_arbiter (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // The stage can take a word when empty or when its current word leaves now.
   assign load_en  = ~out_valid_q | out_ready;
   // Grant is only ever raised on a requesting channel, so no extra in_valid term.
   assign in_ready = grant & {NUM_CH{load_en}};

   // AND-OR select of the granted channel's data from the packed bus.
   always_comb begin
      sel_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_data = sel_data | (in_data[c*DATA_LENGTH +: DATA_LENGTH] & {DATA_LENGTH{grant[c]}});
      end
   end

   // Next state of the output stage and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         if (any_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            if (ARB_MODE == ARB_RR) begin
               // Wrap at NUM_CH-1 so unused index codes are never reached.
               rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset discards any held word.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: round-robin x4, fixed-priority x4 and round-robin x3
// instances run side by side against a behavioural model.
module tb_arb_mux_reg;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0] vld  [3];
   logic [7:0] dat  [3][4];
   logic       ordy [3];

   logic [3:0] rdy0, rdy1;
   logic [2:0] rdy2;
   logic       ov0, ov1, ov2;
   logic [7:0] od0, od1, od2;
   logic [1:0] os0, os1, os2;

   arb_mux_reg #(.DATA_LENGTH(8), .NUM_CH(4), .SEL_W(2), .ARB_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]),
      .in_data({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
      .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));

   arb_mux_reg #(.DATA_LENGTH(8), .NUM_CH(4), .SEL_W(2), .ARB_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]),
      .in_data({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
      .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));

   arb_mux_reg #(.DATA_LENGTH(8), .NUM_CH(3), .SEL_W(2), .ARB_MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[2][2:0]),
      .in_data({dat[2][2], dat[2][1], dat[2][0]}),
      .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));

   logic [3:0] rdy_a [3];
   logic       ov_a  [3];
   logic [7:0] od_a  [3];
   logic [1:0] os_a  [3];

   always_comb begin
      rdy_a[0] = rdy0;  rdy_a[1] = rdy1;  rdy_a[2] = {1'b0, rdy2};
      ov_a[0]  = ov0;   ov_a[1]  = ov1;   ov_a[2]  = ov2;
      od_a[0]  = od0;   od_a[1]  = od1;   od_a[2]  = od2;
      os_a[0]  = os0;   os_a[1]  = os1;   os_a[2]  = os2;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         n_ch [3] = '{4, 4, 3};
   bit         fixed[3] = '{1'b0, 1'b1, 1'b0};
   bit         m_valid [3];
   logic [7:0] m_data  [3];
   int         m_sel   [3];
   int         m_ptr   [3];
   logic [3:0] acc     [3];

   // Channel that wins right now, or -1 when nobody requests.
   function automatic int pick(input int k);
      for (int off = 0; off < n_ch[k]; off++) begin
         int c;
         c = fixed[k] ? off : (m_ptr[k] + off) % n_ch[k];
         if (vld[k][c]) return c;
      end
      return -1;
   endfunction

   function automatic bit can_load(input int k);
      return !m_valid[k] || ordy[k];
   endfunction

   // Model state advances on the same edge as the DUT.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_valid[k] <= 1'b0;
            m_data[k]  <= 8'h00;
            m_sel[k]   <= 0;
            m_ptr[k]   <= 0;
            acc[k]     <= 4'b0;
         end else if (can_load(k) && pick(k) >= 0) begin
            m_valid[k] <= 1'b1;
            m_data[k]  <= dat[k][pick(k)];
            m_sel[k]   <= pick(k);
            if (!fixed[k]) m_ptr[k] <= (pick(k) + 1) % n_ch[k];
            acc[k]     <= 4'(1 << pick(k));
         end else begin
            if (can_load(k)) m_valid[k] <= 1'b0;
            acc[k] <= 4'b0;
         end
      end
   end

   // Compare every DUT output against the model each cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [3:0] exp_rdy;
         exp_rdy = (can_load(k) && pick(k) >= 0) ? 4'(1 << pick(k)) : 4'b0;
         check($sformatf("model in_ready[%0d]", k), 32'(rdy_a[k]), 32'(exp_rdy));
         check($sformatf("model out_valid[%0d]", k), 32'(ov_a[k]), 32'(m_valid[k]));
         check($sformatf("model out_data[%0d]", k), 32'(od_a[k]), 32'(m_data[k]));
         check($sformatf("model out_sel[%0d]", k), 32'(os_a[k]), 32'(m_sel[k]));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 3; k++) begin
         vld[k]  = 4'b0;
         ordy[k] = 1'b1;
         for (int c = 0; c < 4; c++) dat[k][c] = 8'h00;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      check("reset out_valid", 32'(ov0), 32'd0);
      check("reset out_data", 32'(od0), 32'h00);
      check("reset out_sel", 32'(os0), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle after reset out_valid", 32'(ov0), 32'd0);
      end

      // Single requester on channel 2.
      vld[0] = 4'b0100;
      dat[0][2] = 8'hA5;
      #3;
      check("single in_ready", 32'(rdy0), 32'b0100);
      step();
      vld[0] = 4'b0000;
      check("single out_valid", 32'(ov0), 32'd1);
      check("single out_data", 32'(od0), 32'hA5);
      check("single out_sel", 32'(os0), 32'd2);
      check("single rr_ptr", 32'(dut0.rr_ptr_q), 32'd3);
      step();

      // Fresh pointer, then every channel requesting continuously.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 4; c++) dat[k][c] = 8'h10 + 8'(c);
         vld[k] = 4'b1111;
      end
      for (int i = 0; i < 6; i++) begin
         step();
         check("fair out_valid", 32'(ov0), 32'd1);
         check("fair out_sel", 32'(os0), 32'(i % 4));
         check("fair out_data", 32'(od0), 32'(8'h10 + 8'(i % 4)));
         check("fixed all out_sel", 32'(os1), 32'd0);
         check("wrap3 out_sel", 32'(os2), 32'(i % 3));
         check("wrap3 out_data", 32'(od2), 32'(8'h10 + 8'(i % 3)));
      end

      // Backpressure while holding channel 1's word.
      ordy[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #3;
         check("stall in_ready", 32'(rdy0), 32'b0000);
         step();
         check("stall out_valid", 32'(ov0), 32'd1);
         check("stall out_data", 32'(od0), 32'h11);
         check("stall out_sel", 32'(os0), 32'd1);
      end
      ordy[0] = 1'b1;
      #3;
      check("release in_ready", 32'(rdy0), 32'b0100);
      step();
      check("release out_sel", 32'(os0), 32'd2);
      check("release out_data", 32'(od0), 32'h12);

      // Fixed priority: channel 1 beats channel 3 until it drops.
      vld[1] = 4'b1010;
      dat[1][1] = 8'h21;
      dat[1][3] = 8'h23;
      for (int i = 0; i < 4; i++) begin
         step();
         check("fixed ch1 out_sel", 32'(os1), 32'd1);
         check("fixed ch1 out_data", 32'(od1), 32'h21);
      end
      vld[1] = 4'b1000;
      step();
      check("fixed ch3 out_sel", 32'(os1), 32'd3);
      check("fixed ch3 out_data", 32'(od1), 32'h23);

      // Asynchronous reset mid-cycle while a word is held.
      check("pre-reset out_valid", 32'(ov0), 32'd1);
      #1;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) vld[k] = 4'b0;
      #1;
      check("async reset out_valid", 32'(ov0), 32'd0);
      check("async reset out_data", 32'(od0), 32'h00);
      check("async reset out_sel", 32'(os0), 32'd0);
      check("async reset rr_ptr", 32'(dut0.rr_ptr_q), 32'd0);
      check("async reset out_valid3", 32'(ov2), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post-reset idle out_valid", 32'(ov0), 32'd0);
      end

      // Random traffic obeying the hold-until-accepted source rule.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < n_ch[k]; c++) begin
               if (!vld[k][c] || acc[k][c]) begin
                  vld[k][c] = ($urandom_range(0, 1) == 1);
                  dat[k][c] = 8'($urandom);
               end
            end
            ordy[k] = ($urandom_range(0, 3) != 0);
         end
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
